// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with next-PC selection and a circular return-address stack
module pc_ras_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       pc_select,
  input  logic [WIDTH-1:0] jump_data,
  input  logic             ihit,
  input  logic             dhit,
  output logic [WIDTH-1:0] imemaddr,
  output logic [WIDTH-1:0] rtn_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW:0]      r_count;
  logic             r_err;
  logic             w_adv, w_call, w_ret;
  logic [WIDTH-1:0] w_top, w_next;
  assign w_adv     = ihit & ~dhit;
  assign w_call    = w_adv && pc_select == 3'd4;
  assign w_ret     = w_adv && pc_select == 3'd5;
  assign rtn_addr  = r_pc + WIDTH'(4);
  assign imemaddr  = r_pc;
  assign ras_empty = r_count == '0;
  assign ras_full  = r_count == FULL;
  assign ras_err   = r_err;
  assign w_top     = r_stack[r_wptr - 1'b1];
  // next-PC mux; reserved codes fall through to sequential, word alignment forced
  always_comb begin
    w_next = pc_select == 3'd1 ? rtn_addr + jump_data :
             (pc_select == 3'd2 || pc_select == 3'd3 || pc_select == 3'd4) ? jump_data :
             pc_select == 3'd5 ? (ras_empty ? jump_data : w_top) : rtn_addr;
    w_next[1:0] = 2'b00;
  end
  // stack storage is never cleared; the count alone defines which entries are valid
  always_ff @(posedge CLK)
    if (w_call) r_stack[r_wptr] <= rtn_addr;
  // PC, stack pointer, count and sticky error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_adv) begin
      r_pc <= w_next;
      if (w_call) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= ras_full ? r_count : r_count + 1'b1;
        r_err   <= r_err | ras_full;
      end else if (w_ret) begin
        r_wptr  <= ras_empty ? r_wptr : r_wptr - 1'b1;
        r_count <= ras_empty ? r_count : r_count - 1'b1;
        r_err   <= r_err | ras_empty;
      end
    end
  end
endmodule
